// File: rtl/uart_rom_loader_if.sv
// Output bundle of the UART ROM loader: received-byte stream plus the ROM write port.
interface uart_rom_loader_if #(
    parameter int ADDR_W = 12
);
    logic              byte_vld;
    logic [7:0]        byte_data;
    logic              frame_err;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic [ADDR_W:0]   word_cnt;

    modport master (
        output byte_vld, byte_data, frame_err,
        output rom_we, rom_waddr, rom_wdata, word_cnt
    );

    modport slave (
        input byte_vld, byte_data, frame_err,
        input rom_we, rom_waddr, rom_wdata, word_cnt
    );
endinterface

// File: rtl/uart_rom_loader.sv
// 8N1 UART receiver that packs bytes little-endian into 32-bit words and
// streams them into instruction ROM at consecutive word addresses.
module uart_rom_loader #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int ADDR_W    = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    input  logic load_clr,
    uart_rom_loader_if.master bus
);
    localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF    = BIT_CNT / 2;
    localparam int TW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t            state_reg;
    logic              rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [TW-1:0]     timer_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;
    logic              byte_vld_reg, frame_err_reg;
    logic [7:0]        byte_data_reg;
    logic [1:0]        byte_idx_reg;
    logic [7:0]        lane_reg [3];
    logic [ADDR_W-1:0] addr_reg, waddr_hold_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic [31:0]       wdata_hold_reg;
    logic              word_done, write_now;
    logic [31:0]       full_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            byte_vld_reg  <= 1'b0;
            byte_data_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            byte_vld_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    timer_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg) state_reg <= START;
                end
                START: begin
                    if (timer_reg == TW'(HALF - 1)) begin
                        timer_reg   <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_sync_reg ? IDLE : DATA;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (timer_reg == TW'(BIT_CNT - 1)) begin
                        timer_reg              <= '0;
                        shift_reg[bit_idx_reg] <= rx_sync_reg;
                        bit_idx_reg            <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) state_reg <= STOP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (timer_reg == TW'(BIT_CNT - 1)) begin
                        timer_reg <= '0;
                        if (rx_sync_reg) begin
                            byte_vld_reg  <= 1'b1;
                            byte_data_reg <= shift_reg;
                            state_reg     <= IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= WAIT_IDLE;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                WAIT_IDLE: if (rx_sync_reg) state_reg <= IDLE;
                default:   state_reg <= IDLE;
            endcase
        end
    end

    // The fourth byte goes straight to the ROM port; only lanes 0..2 are stored.
    assign word_done = byte_vld_reg && (byte_idx_reg == 2'd3);
    assign write_now = word_done && !load_clr;
    assign full_word = {byte_data_reg, lane_reg[2], lane_reg[1], lane_reg[0]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    lane_reg[gi] <= '0;
                else if (load_clr)
                    lane_reg[gi] <= '0;
                else if (byte_vld_reg && byte_idx_reg == 2'(gi))
                    lane_reg[gi] <= byte_data_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_reg   <= '0;
            addr_reg       <= '0;
            cnt_reg        <= '0;
            waddr_hold_reg <= '0;
            wdata_hold_reg <= '0;
        end else if (load_clr) begin
            byte_idx_reg <= '0;
            addr_reg     <= '0;
            cnt_reg      <= '0;
        end else if (byte_vld_reg) begin
            byte_idx_reg <= byte_idx_reg + 1'b1;
            if (word_done) begin
                addr_reg       <= addr_reg + 1'b1;
                waddr_hold_reg <= addr_reg;
                wdata_hold_reg <= full_word;
                if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Write port shows the live word during the strobe and the last written one otherwise.
    assign bus.byte_vld  = byte_vld_reg;
    assign bus.byte_data = byte_data_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.rom_we    = write_now;
    assign bus.rom_waddr = write_now ? addr_reg : waddr_hold_reg;
    assign bus.rom_wdata = write_now ? full_word : wdata_hold_reg;
    assign bus.word_cnt  = cnt_reg;
endmodule
